// File: rtl/multiplier_arbiter.sv
// -----------------------------------------------------------------------------
// multiplier_arbiter
//   Shares one multi-cycle signed (Booth) multiplier between two requesters,
//   A and B. A request is granted in IDLE, its operands are launched to the
//   multiplier, the product (or a timeout error) is captured, the multiplier is
//   reset for one cycle, and the result is held for the owner until consumed.
//   Priority alternates: after a result is consumed the other requester wins a
//   simultaneous request.
//
// Parameters
//   WIDTH    operand width (product is 2*WIDTH)
//   TIMEOUT  maximum number of WAIT cycles before the request ends in error
//
// Ports
//   clk, reset                      clock (rising edge), async active-low reset
//   a_valid/b_valid                 requester has an operand pair pending
//   a_ready/b_ready                 operand pair accepted this cycle (IDLE only)
//   a_m,a_q / b_m,b_q               signed multiplicand / multiplier per requester
//   a_res_valid/b_res_valid         result available for that requester
//   a_res_ready/b_res_ready         requester consumes its result
//   res_data, res_err               signed product, timeout flag
//   mul_valid, mul_m, mul_q         start pulse and held operands to multiplier
//   mul_ready, mul_product          multiplier done level and its product
//   mul_rst_n                       active-low reset to the multiplier
//   busy                            arbiter is not in IDLE
// -----------------------------------------------------------------------------
module multiplier_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 40
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        a_valid,
    input  logic                        b_valid,
    output logic                        a_ready,
    output logic                        b_ready,
    input  logic signed [WIDTH-1:0]     a_m,
    input  logic signed [WIDTH-1:0]     a_q,
    input  logic signed [WIDTH-1:0]     b_m,
    input  logic signed [WIDTH-1:0]     b_q,
    output logic                        a_res_valid,
    output logic                        b_res_valid,
    input  logic                        a_res_ready,
    input  logic                        b_res_ready,
    output logic signed [2*WIDTH-1:0]   res_data,
    output logic                        res_err,
    output logic                        mul_valid,
    output logic signed [WIDTH-1:0]     mul_m,
    output logic signed [WIDTH-1:0]     mul_q,
    input  logic                        mul_ready,
    input  logic signed [2*WIDTH-1:0]   mul_product,
    output logic                        mul_rst_n,
    output logic                        busy
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CLEAR   = 3'd3,
        RESPOND = 3'd4
    } state_t;

    state_t                     state_q;
    logic                       ptr_q;      // 0: A has priority, 1: B
    logic                       owner_q;    // 0: A owns the multiplier, 1: B
    logic [CNT_W-1:0]           cnt_q;
    logic signed [WIDTH-1:0]    mul_m_q;
    logic signed [WIDTH-1:0]    mul_q_q;
    logic signed [2*WIDTH-1:0]  res_data_q;
    logic                       res_err_q;

    logic win_a;
    logic win_b;
    logic owner_rdy;

    // Arbitration is combinational so the grant lands in the same IDLE cycle.
    // Gated by reset so no ready can appear while the block is held in reset.
    always_comb begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (reset && (state_q == IDLE)) begin
            if (a_valid && (!b_valid || !ptr_q)) begin
                win_a = 1'b1;
            end else if (b_valid) begin
                win_b = 1'b1;
            end
        end
    end

    assign owner_rdy = owner_q ? b_res_ready : a_res_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            cnt_q      <= '0;
            mul_m_q    <= '0;
            mul_q_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_a || win_b) begin
                        owner_q <= win_b;
                        mul_m_q <= win_b ? b_m : a_m;
                        mul_q_q <= win_b ? b_q : a_q;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done multiplier beats the timeout on the final count.
                    if (mul_ready) begin
                        res_data_q <= mul_product;
                        res_err_q  <= 1'b0;
                        state_q    <= CLEAR;
                    end else if (cnt_q == CNT_LAST) begin
                        res_data_q <= '0;
                        res_err_q  <= 1'b1;
                        state_q    <= CLEAR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= RESPOND;
                end
                RESPOND: begin
                    if (owner_rdy) begin
                        ptr_q   <= ~owner_q;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_ready     = win_a;
    assign b_ready     = win_b;
    assign mul_valid   = (state_q == LAUNCH);
    assign busy        = (state_q != IDLE);
    assign a_res_valid = (state_q == RESPOND) && !owner_q;
    assign b_res_valid = (state_q == RESPOND) && owner_q;
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign mul_m       = mul_m_q;
    assign mul_q       = mul_q_q;
    // Multiplier is held in reset with the arbiter and pulsed in CLEAR.
    assign mul_rst_n   = reset && (state_q != CLEAR);

endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width shared with the Booth multiplier datapath.
REQ-002 Parameter TIMEOUT, default 40, maximum WAIT cycles allowed for mul_ready.
REQ-003 clk  in  1  single clock; all flops rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 a_valid, b_valid  in  1 each  requester A/B has an operand pair pending.
REQ-006 a_ready, b_ready  out  1 each  requester A/B operand pair accepted this cycle.
REQ-007 a_m, a_q, b_m, b_q  in  WIDTH each  signed multiplicand (m) and multiplier (q) per requester.
REQ-008 a_res_valid, b_res_valid  out  1 each  result available for requester A/B.
REQ-009 a_res_ready, b_res_ready  in  1 each  requester A/B consumes its result.
REQ-010 res_data  out  2*WIDTH  signed product for the current owner.
REQ-011 res_err  out  1  the current result was produced by timeout.
REQ-012 mul_valid  out  1  start pulse to the multiplier.
REQ-013 mul_m, mul_q  out  WIDTH each  operands held stable to the multiplier.
REQ-014 mul_ready  in  1  multiplier done, level, held until the multiplier is reset.
REQ-015 mul_product  in  2*WIDTH  multiplier product, valid while mul_ready=1.
REQ-016 mul_rst_n  out  1  active-low reset to the multiplier = reset AND NOT(state==CLEAR).
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT, CLEAR, RESPOND, and any illegal encoding SHALL go to IDLE.
REQ-019 In IDLE, the arbiter SHALL assert exactly one of a_ready/b_ready, combinationally, for the winning valid requester: the sole requester if only one is valid, otherwise the requester named by the priority pointer.
REQ-020 On the grant handshake (valid&ready in IDLE), the arbiter SHALL register operands and owner and go to LAUNCH next cycle; ready SHALL be 0 in all other states.
REQ-021 LAUNCH SHALL last one cycle with mul_valid=1, clear the timeout counter, then go to WAIT.
REQ-022 mul_m/mul_q SHALL drive the registered operands from LAUNCH through RESPOND, unchanged.
REQ-023 In WAIT with mul_ready=1, the arbiter SHALL register mul_product into res_data, clear res_err and go to CLEAR.
REQ-024 In WAIT with mul_ready=0, the counter SHALL increment; when it reaches TIMEOUT-1 without mul_ready, res_data SHALL be 0, res_err=1, and the FSM SHALL go to CLEAR.
REQ-025 If mul_ready=1 on the same cycle the counter reaches TIMEOUT-1, mul_ready SHALL win with a normal result.
REQ-026 CLEAR SHALL last one cycle with mul_rst_n=0, returning the multiplier to its idle state, then go to RESPOND.
REQ-027 In RESPOND, only the owner's res_valid SHALL be 1, with res_data/res_err stable until the owner's res_ready=1.
REQ-028 On the cycle the owner's res_ready=1 in RESPOND, the FSM SHALL go to IDLE and set the priority pointer to the non-owner.
REQ-029 The non-owner's valid SHALL be ignored until IDLE, and requests SHALL never be dropped or duplicated.
REQ-030 The minimum service time SHALL be grant + LAUNCH + WAIT(n) + CLEAR + RESPOND, and back-to-back grants SHALL be separated by at least one IDLE cycle.

Reset
REQ-031 While reset=0, outputs SHALL be: state IDLE, priority pointer=A, ready/res_valid/mul_valid/res_err/busy=0, res_data=0, mul_m/mul_q=0, counter=0, mul_rst_n=0.
REQ-032 Reset asserted in any state, including mid-WAIT, SHALL abort the operation immediately with no result delivered, and the aborted request SHALL not be retried.

Verification
REQ-033 A only, a_m=3, a_q=-5 (0xFB) -> a_ready one cycle, mul_valid one cycle later, a_res_valid with res_data=0xFFF1, res_err=0, mul_rst_n low exactly one cycle before RESPOND.
REQ-034 A and B valid on the same cycle after reset, A=7x9, B=-128x-128 -> A served first with 0x003F, then B with 0x4000, and b_ready not before A's res handshake.
REQ-035 mul_ready tied 0 -> after TIMEOUT WAIT cycles, res_err=1, res_data=0x0000, CLEAR pulse, then IDLE after res_ready.
REQ-036 Owner's res_ready held low 5 cycles in RESPOND -> res_valid and res_data held constant, other requester not granted, busy=1.
REQ-037 reset pulsed low during WAIT -> all outputs at reset values asynchronously, mul_rst_n=0, and no res_valid afterwards for that request.
REQ-038 Alternating continuous requests from A and B -> grants strictly alternate A,B,A,B.
